// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch FSM
// encoding and the fetch-stage IF/ID record.
package cpu_pkg;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADD_I = 6'h08;
  localparam logic [5:0] OP_SUB_I = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int AMT_MSB    = 10;
  localparam int AMT_LSB    = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // FETCH: request live; WAIT: skid full, no request; DROP: stale request in flight
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_split.sv
// Pure combinational decode of an instruction word into its fields;
// shared by the fetch stage outputs and the control unit.
module instr_split
  import cpu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_amount,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_target
);

  assign o_op     = i_instr[OP_MSB:OP_LSB];
  assign o_rs     = i_instr[RS_MSB:RS_LSB];
  assign o_rt     = i_instr[RT_MSB:RT_LSB];
  assign o_rd     = i_instr[RD_MSB:RD_LSB];
  assign o_amount = i_instr[AMT_MSB:AMT_LSB];
  assign o_funct  = i_instr[FUNCT_MSB:FUNCT_LSB];
  assign o_imm    = i_instr[IMM_MSB:IMM_LSB];
  assign o_target = i_instr[TARGET_MSB:TARGET_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives one outstanding memory request, holds the
// IF/ID register with a one-entry skid, and handles redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [5:0]  o_op,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_amount,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm,
  output logic [25:0] o_target
);

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_target;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  ifid_t       r_skid;
  logic        r_skid_valid;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_fetch_pc_inc;
  logic        w_out_free;

  assign w_redirect_pc  = align_pc(i_redirect_pc);
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
  assign w_out_free     = !r_valid || !i_stall;

  // Request drops combinationally during reset so memory sees the cancel at once.
  assign o_imem_req  = !i_rst && (r_state != ST_WAIT);
  assign o_imem_addr = r_fetch_pc;

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_fetch_pc   <= RESET_PC;
      r_target     <= RESET_PC;
      r_valid      <= 1'b0;
      r_instr      <= 32'h0;
      r_pc         <= 32'h0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_redirect) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            if (i_imem_ack) begin
              r_fetch_pc <= w_redirect_pc;
            end else begin
              // The request on the old address must still complete; remember where to go.
              r_target <= w_redirect_pc;
              r_state  <= ST_DROP;
            end
          end else if (i_imem_ack) begin
            r_fetch_pc <= w_fetch_pc_inc;
            if (w_out_free) begin
              r_instr <= i_imem_rdata;
              r_pc    <= r_fetch_pc;
              r_valid <= 1'b1;
            end else begin
              r_skid.instr <= i_imem_rdata;
              r_skid.pc    <= r_fetch_pc;
              r_skid_valid <= 1'b1;
              r_state      <= ST_WAIT;
            end
          end else if (r_valid && !i_stall) begin
            r_valid <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (i_redirect) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_fetch_pc   <= w_redirect_pc;
            r_state      <= ST_FETCH;
          end else if (!i_stall) begin
            r_instr      <= r_skid.instr;
            r_pc         <= r_skid.pc;
            r_valid      <= r_skid_valid;
            r_skid_valid <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end

        ST_DROP: begin
          if (i_imem_ack) begin
            r_fetch_pc <= i_redirect ? w_redirect_pc : r_target;
            r_state    <= ST_FETCH;
          end else if (i_redirect) begin
            r_target <= w_redirect_pc;
          end
        end

        default: begin
          r_state      <= ST_FETCH;
          r_valid      <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

  instr_split u_instr_split (
    .i_instr  (r_instr),
    .o_op     (o_op),
    .o_rs     (o_rs),
    .o_rt     (o_rt),
    .o_rd     (o_rd),
    .o_amount (o_amount),
    .o_funct  (o_funct),
    .o_imm    (o_imm),
    .o_target (o_target)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-level model.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;

  fetch_unit_if imem();

  logic        o_valid;
  logic [31:0] o_instr, o_pc, o_pc_plus4;
  logic [5:0]  o_op, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_amount;
  logic [15:0] o_imm;
  logic [25:0] o_target;

  logic [31:0] d2_addr, d2_instr, d2_pc, d2_pc4;
  logic        d2_req, d2_valid;
  logic [5:0]  d2_op, d2_funct;
  logic [4:0]  d2_rs, d2_rt, d2_rd, d2_amount;
  logic [15:0] d2_imm;
  logic [25:0] d2_target;

  int n_checks = 0;
  int n_err = 0;
  int wait_cnt = 0;
  int fixed_lat = 0;

  ent_t        mq[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_tgt = 32'h0;
  bit          m_stale = 1'b0;
  bit          m_ok = 1'b0;

  always #5 i_clk = ~i_clk;

  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_addr(imem.imem_addr), .o_imem_req(imem.imem_req),
    .i_imem_ack(imem.imem_ack), .i_imem_rdata(imem.imem_rdata),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
    .o_op(o_op), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_amount(o_amount),
    .o_funct(o_funct), .o_imm(o_imm), .o_target(o_target)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_addr(d2_addr), .o_imem_req(d2_req),
    .i_imem_ack(imem.imem_ack), .i_imem_rdata(imem.imem_rdata),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(d2_valid), .o_instr(d2_instr), .o_pc(d2_pc), .o_pc_plus4(d2_pc4),
    .o_op(d2_op), .o_rs(d2_rs), .o_rt(d2_rt), .o_rd(d2_rd), .o_amount(d2_amount),
    .o_funct(d2_funct), .o_imm(d2_imm), .o_target(d2_target)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0109_5020;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int next_lat();
    if (fixed_lat >= 0) return fixed_lat;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: a queue of at most two delivered-but-unconsumed words
  // (front = IF/ID), the next program-order address, and a pending target
  // while a stale request is still in flight.
  task automatic model_update(input bit rst, input bit stall, input bit redir,
                              input logic [31:0] rpc, input bit ack,
                              input logic [31:0] rdata, input bit req);
    logic [31:0] tgt;
    bit ack_eff;
    tgt = {rpc[31:2], 2'b00};
    ack_eff = ack && req;
    if (rst) begin
      mq.delete();
      m_pc = RST_PC;
      m_stale = 1'b0;
      m_ok = 1'b1;
    end else if (redir) begin
      mq.delete();
      if (m_stale) begin
        if (ack_eff) begin m_pc = tgt; m_stale = 1'b0; end
        else m_tgt = tgt;
      end else if (ack_eff || !req) begin
        m_pc = tgt;
      end else begin
        m_stale = 1'b1;
        m_tgt = tgt;
      end
    end else if (m_stale) begin
      if (ack_eff) begin m_pc = m_tgt; m_stale = 1'b0; end
    end else begin
      if (!stall && mq.size() > 0) void'(mq.pop_front());
      if (ack_eff) begin
        mq.push_back('{instr: rdata, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] rpc);
    bit   exp_req;
    ent_t f;
    @(negedge i_clk);
    i_rst = rst;
    i_stall = stall;
    i_redirect = redir;
    i_redirect_pc = rpc;
    #1;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = $urandom;
    if (rst) begin
      wait_cnt = next_lat();
    end else if (imem.imem_req) begin
      if (wait_cnt == 0) begin
        imem.imem_ack = 1'b1;
        imem.imem_rdata = memword(imem.imem_addr);
        wait_cnt = next_lat();
      end else begin
        wait_cnt--;
      end
    end
    exp_req = !rst && (mq.size() < 2);
    chk("req", 32'(imem.imem_req), 32'(exp_req));
    if (m_ok) begin
      if (exp_req) chk("addr", imem.imem_addr, m_pc);
      chk("valid", 32'(o_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        f = mq[0];
        chk("instr", o_instr, f.instr);
        chk("pc", o_pc, f.pc);
        chk("pc_plus4", o_pc_plus4, f.pc + 32'd4);
        chk("fields_r", {o_op, o_rs, o_rt, o_rd, o_amount, o_funct}, f.instr);
        chk("field_imm", 32'(o_imm), 32'(f.instr[15:0]));
        chk("field_target", 32'(o_target), 32'(f.instr[25:0]));
      end
    end
    @(posedge i_clk);
    model_update(rst, stall, redir, rpc, imem.imem_ack, imem.imem_rdata, exp_req);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_addr", imem.imem_addr, RST_PC);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
  endtask

  initial begin
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    fixed_lat = 0;

    // back-to-back acks, first two words
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq0_valid", 32'(o_valid), 32'h1);
    chk("seq0_pc", o_pc, 32'h0);
    chk("seq0_op", 32'(o_op), 32'h08);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq1_pc", o_pc, 32'h4);
    chk("seq1_op", 32'(o_op), 32'h00);
    chk("seq1_funct", 32'(o_funct), 32'h20);
    chk("seq1_rd", 32'(o_rd), 32'h0A);

    // three-cycle memory latency on the second word
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_cnt = 2;
    chk("lat_addr0", imem.imem_addr, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("lat_addr1", imem.imem_addr, 32'h4);
    chk("lat_req1", 32'(imem.imem_req), 32'h1);
    chk("lat_gap_valid", 32'(o_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("lat_addr2", imem.imem_addr, 32'h4);
    chk("lat_gap_valid2", 32'(o_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("lat_done_pc", o_pc, 32'h4);
    chk("lat_next_addr", imem.imem_addr, 32'h8);

    // four stall cycles fill the skid, then drain in order
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_req", 32'(imem.imem_req), 32'h0);
      chk("stall_instr", o_instr, 32'h2008_0005);
      chk("stall_pc", o_pc, 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_pc", o_pc, 32'h4);
    chk("drain_instr", o_instr, 32'h0109_5020);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_next_pc", o_pc, 32'h8);

    // redirect while a request to 0x8 is outstanding
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_cnt = 1;
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("drop_addr", imem.imem_addr, 32'h8);
    chk("drop_req", 32'(imem.imem_req), 32'h1);
    chk("drop_valid", 32'(o_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_done_addr", imem.imem_addr, 32'h40);
    chk("drop_discard", 32'(o_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_first_pc", o_pc, 32'h40);
    chk("drop_first_valid", 32'(o_valid), 32'h1);

    // redirect together with stall while the skid is full
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wait_req", 32'(imem.imem_req), 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("wredir_valid", 32'(o_valid), 32'h0);
    chk("wredir_addr", imem.imem_addr, 32'h100);
    wait_cnt = 5;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wredir_skid_empty", 32'(o_valid), 32'h0);

    // wrap of RESET_PC, and reset in the middle of DROP
    do_reset();
    chk("wrap_rst_addr", d2_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", d2_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", d2_pc4, 32'h0);
    chk("wrap_next_addr", d2_addr, 32'h0);
    wait_cnt = 3;
    step(1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drop_rst_addr", imem.imem_addr, RST_PC);
    chk("drop_rst_valid", 32'(o_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_rst_fetch_pc", o_pc, RST_PC);

    // randomized traffic
    fixed_lat = -1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit r_rst, r_stall, r_redir;
      logic [31:0] rpc;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_stall = ($urandom_range(0, 99) < 35);
      r_redir = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0: rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1: rpc = $urandom;
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      step(r_rst, r_stall, r_redir, rpc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
